// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// Consumed by dmem_responder and dmem_array.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Encoding of the request size field.
  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  // Width of the wait-state counter; LATENCY must fit in it.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: one byte-masked write port, one registered read port.
// Contents are zero at time 0 and are never cleared by reset.
module dmem_array #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [3:0]               wmask_i,
  input  logic [$clog2(DEPTH)-1:0] widx_i,
  input  logic [31:0]              wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] ridx_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH] = '{default: '0};
  logic [31:0] rdata_q = '0;
  logic [31:0] wmerge;

  // Lanes outside the mask keep their stored value.
  always_comb begin
    wmerge = mem_q[widx_i];
    for (int b = 0; b < 4; b++) begin
      if (wmask_i[b]) begin
        wmerge[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[widx_i] <= wmerge;
    end
    if (re_i) begin
      rdata_q <= mem_q[ridx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store target with configurable wait states and access-error reporting.
// Byte accesses (lb/sb) are compiled in only when DMEM_BYTE_ACCESS_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic        req_size_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CntInit = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic             err_q;
  logic             write_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;

  logic        accept;
  logic        commit;
  logic        from_idle;
  logic        c_write;
  logic        c_word;
  logic        c_err;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [31:0] c_wdata_lane;
  logic [3:0]  c_mask;
  logic [31:0] rd_word;

  assign accept    = req_ready_q & req_valid_i;
  assign from_idle = (state_q == StIdle);
  assign commit    = (from_idle & accept & (LATENCY == 0)) |
                     ((state_q == StWait) & (cnt_q == '0));

  // A zero-latency request commits on its own acceptance edge, before the latches hold it.
  assign c_write = from_idle ? req_write_i : write_q;
  assign c_addr  = from_idle ? req_addr_i  : addr_q;
  assign c_wdata = from_idle ? req_wdata_i : wdata_q;

`ifdef DMEM_BYTE_ACCESS_EN
  logic       size_q;
  logic       c_size;
  logic [7:0] lane;

  assign c_size = from_idle ? req_size_i : size_q;
  assign c_word = (c_size == SIZE_WORD);

  always_comb begin
    c_mask       = 4'hF;
    c_wdata_lane = c_wdata;
    if (!c_word) begin
      c_mask       = 4'b0001 << c_addr[1:0];
      c_wdata_lane = {4{c_wdata[7:0]}};
    end
  end
`else
  logic unused_size;

  assign unused_size  = req_size_i;
  assign c_word       = 1'b1;
  assign c_mask       = 4'hF;
  assign c_wdata_lane = c_wdata;
`endif

  assign c_err = ((c_addr >> (AW + 2)) != 32'd0) | (c_word & (c_addr[1:0] != 2'b00));

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (commit & c_write & ~c_err),
    .wmask_i(c_mask),
    .widx_i (c_addr[AW+1:2]),
    .wdata_i(c_wdata_lane),
    .re_i   (commit & ~c_write & ~c_err),
    .ridx_i (c_addr[AW+1:2]),
    .rdata_o(rd_word)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
`ifdef DMEM_BYTE_ACCESS_EN
      size_q      <= SIZE_WORD;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            write_q     <= req_write_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
`ifdef DMEM_BYTE_ACCESS_EN
            size_q      <= req_size_i;
`endif
            cnt_q       <= CntInit;
            state_q     <= StWait;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        StWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
      // Commit overrides the WAIT bookkeeping above (and the IDLE path when LATENCY is 0).
      if (commit) begin
        state_q     <= StResp;
        rsp_valid_q <= 1'b1;
        err_q       <= c_err;
      end
    end
  end

  // Read data comes straight off the array register, which only updates on commit.
  always_comb begin
    rsp_rdata_o = '0;
`ifdef DMEM_BYTE_ACCESS_EN
    lane = rd_word[7:0];
`endif
    if (rsp_valid_q && !err_q && !write_q) begin
      rsp_rdata_o = rd_word;
`ifdef DMEM_BYTE_ACCESS_EN
      if (size_q == SIZE_BYTE) begin
        case (addr_q[1:0])
          2'd0:    lane = rd_word[7:0];
          2'd1:    lane = rd_word[15:8];
          2'd2:    lane = rd_word[23:16];
          default: lane = rd_word[31:24];
        endcase
        rsp_rdata_o = {{24{lane[7]}}, lane};
      end
`endif
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance for function, errors, backpressure
// and reset, plus a LATENCY=0 instance for back-to-back throughput.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;
`ifdef DMEM_BYTE_ACCESS_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, req_write, req_size, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        rst0_n, req_valid0, req_write0, req_size0, rsp_ready0;
  logic [31:0] req_addr0, req_wdata0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_size_i(req_size), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst0_n), .req_valid_i(req_valid0), .req_ready_o(req_ready0),
    .req_write_i(req_write0), .req_size_i(req_size0), .req_addr_i(req_addr0),
    .req_wdata_i(req_wdata0), .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0),
    .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err0)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    string       name;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  exp_t sb_q[$];
  exp_t sb0_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;

  vec_t v0[6] = '{
    '{1'b1, 32'h0,     32'h11111111, 32'h0,        1'b0},
    '{1'b1, 32'h4,     32'h22222222, 32'h0,        1'b0},
    '{1'b0, 32'h0,     32'h0,        32'h11111111, 1'b0},
    '{1'b0, 32'h4,     32'h0,        32'h22222222, 1'b0},
    '{1'b0, 32'h2,     32'h0,        32'h0,        1'b1},
    '{1'b1, 32'd1024,  32'h5,        32'h0,        1'b1}
  };

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endfunction

  function automatic void fail_now(input string nm, input string what);
    n_checks++;
    n_errs++;
    $display("FAIL %s: %s", nm, what);
  endfunction

  // Monitor for the LATENCY=2 instance.
  logic        seen_v = 1'b0;
  logic [31:0] held   = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen_v <= 1'b0;
    end else if (rsp_valid) begin
      check("req_ready low while rsp_valid", {31'b0, req_ready}, 32'd0);
      if (sb_q.size() == 0) begin
        fail_now("unexpected response", "rsp_valid with nothing outstanding");
      end else begin
        if (!seen_v) check({sb_q[0].name, " latency"}, 32'(cyc - sb_q[0].acc_cyc), LAT + 1);
        else check({sb_q[0].name, " rdata stable"}, rsp_rdata, held);
        if (rsp_ready) begin
          e = sb_q.pop_front();
          check({e.name, " rdata"}, rsp_rdata, e.rdata);
          check({e.name, " err"}, {31'b0, rsp_err}, {31'b0, e.err});
        end
      end
      seen_v <= !rsp_ready;
      held   <= rsp_rdata;
    end else begin
      seen_v <= 1'b0;
    end
  end

  // Monitor for the LATENCY=0 instance (rsp_ready tied high).
  always @(negedge clk) begin
    exp_t e;
    if (rst0_n && rsp_valid0) begin
      if (sb0_q.size() == 0) begin
        fail_now("L0 unexpected response", "rsp_valid with nothing outstanding");
      end else begin
        e = sb0_q.pop_front();
        check({e.name, " latency"}, 32'(cyc - e.acc_cyc), 32'd1);
        check({e.name, " rdata"}, rsp_rdata0, e.rdata);
        check({e.name, " err"}, {31'b0, rsp_err0}, {31'b0, e.err});
      end
    end
  end

  task automatic issue(input logic wr, input logic sz, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                       input string nm, input bit track);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    req_write = wr; req_size = sz; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    while (!req_ready) begin
      @(negedge clk);
      t++;
      if (t > 40) begin
        fail_now(nm, "req_ready never seen (got 0, required 1)");
        req_valid = 1'b0;
        return;
      end
    end
    if (track) begin
      e.rdata = erd; e.err = eerr; e.acc_cyc = cyc; e.name = nm;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (sb_q.size() != 0) begin
      @(negedge clk);
      t++;
      if (t > 40) begin
        fail_now(nm, "response never arrived (rsp_valid&rsp_ready not seen)");
        sb_q.delete();
        return;
      end
    end
  endtask

  task automatic op(input logic wr, input logic sz, input logic [31:0] addr,
                    input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                    input string nm);
    issue(wr, sz, addr, wd, erd, eerr, nm, 1'b1);
    drain(nm);
  endtask

  task automatic wait_rsp_valid(input string nm);
    int t;
    t = 0;
    while (!rsp_valid && t <= 20) begin
      @(negedge clk);
      t++;
    end
    if (!rsp_valid) fail_now(nm, "rsp_valid never rose (got 0, required 1)");
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, " req_ready"}, {31'b0, req_ready}, 32'd0);
    check({nm, " rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({nm, " rsp_rdata"}, rsp_rdata, 32'd0);
    check({nm, " rsp_err"}, {31'b0, rsp_err}, 32'd0);
  endtask

  initial begin
    exp_t e;
    int   t, prev;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    rst0_n = 1'b0; req_valid0 = 1'b0; req_write0 = 1'b0; req_size0 = 1'b0;
    req_addr0 = '0; req_wdata0 = '0; rsp_ready0 = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("in reset");
    check("L0 in reset req_ready", {31'b0, req_ready0}, 32'd0);
    rst_n = 1'b1;
    rst0_n = 1'b1;

    op(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw 0x10");
    op(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw 0x10");
    op(1'b1, 1'b1, 32'h11, 32'h80, 32'h0, !BYTE_EN, "sb 0x11");
    op(1'b0, 1'b0, 32'h10, 32'h0, BYTE_EN ? 32'hDEAD80EF : 32'hDEADBEEF, 1'b0, "lw 0x10 after sb");
    op(1'b0, 1'b1, 32'h11, 32'h0, BYTE_EN ? 32'hFFFFFF80 : 32'h0, !BYTE_EN, "lb 0x11");
    op(1'b0, 1'b1, 32'h13, 32'h0, BYTE_EN ? 32'hFFFFFFDE : 32'h0, !BYTE_EN, "lb 0x13");
    op(1'b1, 1'b1, 32'h16, 32'hFFFFFF5A, 32'h0, !BYTE_EN, "sb 0x16");
    op(1'b0, 1'b0, 32'h14, 32'h0, BYTE_EN ? 32'h005A0000 : 32'h0, 1'b0, "lw 0x14");
    op(1'b0, 1'b1, 32'h16, 32'h0, BYTE_EN ? 32'h0000005A : 32'h0, !BYTE_EN, "lb 0x16");
    op(1'b0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, "lw misaligned 0x13");
    op(1'b1, 1'b0, 32'd1024, 32'hFFFFFFFF, 32'h0, 1'b1, "sw out of range");
    op(1'b0, 1'b0, 32'd1020, 32'h0, 32'h0, 1'b0, "lw last word");
    op(1'b0, 1'b0, 32'd1024, 32'h0, 32'h0, 1'b1, "lw out of range");
    op(1'b1, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, "sw 0x20");
    op(1'b0, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "lw 0x20");

    // Backpressure with a stray request pulse that must be ignored.
    rsp_ready = 1'b0;
    issue(1'b0, 1'b0, 32'h10, 32'h0, BYTE_EN ? 32'hDEAD80EF : 32'hDEADBEEF, 1'b0,
          "lw 0x10 backpressure", 1'b1);
    wait_rsp_valid("backpressure");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("backpressure rsp_valid held", {31'b0, rsp_valid}, 32'd1);
      if (i == 2) begin
        req_write = 1'b1; req_size = 1'b0; req_addr = 32'h40; req_wdata = 32'hBAD0BAD0;
        req_valid = 1'b1;
      end
      if (i == 3) req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    drain("backpressure");
    op(1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, "lw 0x40 after ignored pulse");

    // Reset while a response is being held.
    rsp_ready = 1'b0;
    issue(1'b0, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "lw 0x20 reset in RESP", 1'b1);
    wait_rsp_valid("reset in RESP");
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("reset in RESP");
    sb_q.delete();
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset while a store is still waiting to commit.
    issue(1'b1, 1'b0, 32'h20, 32'h12345678, 32'h0, 1'b0, "sw 0x20 killed", 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("reset in WAIT");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op(1'b0, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "lw 0x20 after killed store");
    op(1'b0, 1'b0, 32'h10, 32'h0, BYTE_EN ? 32'hDEAD80EF : 32'hDEADBEEF, 1'b0,
       "lw 0x10 after reset");

    // Zero-latency instance: hold req_valid high, one acceptance every two cycles.
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_write0 = v0[i].wr; req_addr0 = v0[i].addr; req_wdata0 = v0[i].wd;
      req_size0 = 1'b0; req_valid0 = 1'b1;
      t = 0;
      while (!req_ready0 && t <= 20) begin
        @(negedge clk);
        t++;
      end
      if (!req_ready0) begin
        fail_now("L0 accept", "req_ready never seen (got 0, required 1)");
        break;
      end
      if (i > 0) check("L0 accept spacing", 32'(cyc - prev), 32'd2);
      prev = cyc;
      e.rdata = v0[i].erd; e.err = v0[i].eerr; e.acc_cyc = cyc;
      e.name = $sformatf("L0 vec%0d", i);
      sb0_q.push_back(e);
      @(posedge clk);
      #1;
    end
    req_valid0 = 1'b0;
    t = 0;
    while (sb0_q.size() != 0 && t <= 20) begin
      @(negedge clk);
      t++;
    end
    if (sb0_q.size() != 0) fail_now("L0 drain", "responses outstanding at end");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
